// File: rtl/ap_pointer_file.sv
// ---------------------------------------------------------------------------
// ap_pointer_file
//
// Purpose:
//    Bank of eight address-pointer registers that sits directly after the AP
//    selector. Each accepted command applies one operation to the pointer
//    picked by APSel and returns the updated value as the memory address for
//    the datapath. A CLRALL command sweeps every pointer back to RESET_VAL,
//    one pointer per cycle, while the block refuses new commands.
//
// Ports:
//    clk         system clock, all logic on the rising edge
//    rst         synchronous, active-high reset
//    APSel       pointer index, sampled only on the accept cycle
//    op_valid    command strobe
//    op          operation code (NOP/LOAD/INC/DEC/ADD/READ/CLRALL/reserved)
//    data_in     load value (LOAD) or two's-complement offset (ADD)
//    op_ready    high when a command can be accepted this cycle
//    addr_out    registered post-operation value of the addressed pointer
//    addr_valid  one-cycle pulse: addr_out updated by the last accepted command
//    wrap        one-cycle pulse with addr_valid: arithmetic wrapped modulo 2^ADDR_W
// ---------------------------------------------------------------------------
module ap_pointer_file #(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        APSel,
   input  logic              op_valid,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] data_in,
   output logic              op_ready,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   output logic              wrap
);

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_INC    = 3'b010;
   localparam logic [2:0] OP_DEC    = 3'b011;
   localparam logic [2:0] OP_ADD    = 3'b100;
   localparam logic [2:0] OP_READ   = 3'b101;
   localparam logic [2:0] OP_CLRALL = 3'b110;

   localparam logic [ADDR_W+1:0] EXT_ONE = {{(ADDR_W+1){1'b0}}, 1'b1};

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   state_t            r_state;
   logic [2:0]        r_clrCnt;
   logic [ADDR_W-1:0] r_ptr [8];
   logic              r_ready;
   logic [ADDR_W-1:0] r_addr;
   logic              r_valid;
   logic              r_wrap;

   logic              w_accept;
   logic [ADDR_W-1:0] w_cur;
   logic [ADDR_W+1:0] w_ext;
   logic [ADDR_W+1:0] w_sum;
   logic [ADDR_W-1:0] w_new;
   logic              w_wrap;
   logic              w_report;

   assign op_ready   = r_ready;
   assign addr_out   = r_addr;
   assign addr_valid = r_valid;
   assign wrap       = r_wrap;

   assign w_accept = op_valid && r_ready;

   // Next value of the selected pointer. The arithmetic is carried out two
   // bits wider than the pointer so that the true (unbounded) result is
   // visible: any set bit above the pointer width means the result fell
   // below zero or rose past all-ones, i.e. the pointer wrapped.
   always_comb begin
      w_cur    = r_ptr[APSel];
      w_ext    = {2'b00, w_cur};
      w_sum    = w_ext;
      w_report = 1'b0;
      case (op)
         OP_LOAD: begin
            w_sum    = {2'b00, data_in};
            w_report = 1'b1;
         end
         OP_INC: begin
            w_sum    = w_ext + EXT_ONE;
            w_report = 1'b1;
         end
         OP_DEC: begin
            w_sum    = w_ext - EXT_ONE;
            w_report = 1'b1;
         end
         OP_ADD: begin
            w_sum    = w_ext + {{2{data_in[ADDR_W-1]}}, data_in};
            w_report = 1'b1;
         end
         OP_READ: begin
            w_report = 1'b1;
         end
         default: begin
            w_report = 1'b0;
         end
      endcase
      w_new  = w_sum[ADDR_W-1:0];
      w_wrap = |w_sum[ADDR_W+1:ADDR_W];
   end

   // Control FSM, pointer bank and registered outputs. In IDLE every cycle
   // can accept a command; the result is written back to the pointer and to
   // addr_out on the same edge, so a following command on the same pointer
   // sees the fresh value. CLRALL moves to CLEAR, which writes one pointer
   // per cycle for eight cycles and then reopens op_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_ptr[i] <= RESET_VAL;
         end
         r_state  <= S_IDLE;
         r_clrCnt <= 3'd0;
         r_addr   <= '0;
         r_valid  <= 1'b0;
         r_wrap   <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (op == OP_CLRALL) begin
                     r_state  <= S_CLEAR;
                     r_clrCnt <= 3'd0;
                     r_ready  <= 1'b0;
                  end else if (w_report) begin
                     r_ptr[APSel] <= w_new;
                     r_addr       <= w_new;
                     r_valid      <= 1'b1;
                     r_wrap       <= w_wrap;
                  end
               end
            end
            S_CLEAR: begin
               r_ptr[r_clrCnt] <= RESET_VAL;
               r_clrCnt        <= r_clrCnt + 3'd1;
               if (r_clrCnt == 3'd7) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ap_pointer_file.sv
// ---------------------------------------------------------------------------
// tb_ap_pointer_file
//
// Purpose:
//    Self-checking bench for ap_pointer_file. The driver keeps a plain array
//    model of the eight pointers and pushes the expected address/wrap for
//    every reporting command into a queue; a monitor pops the queue whenever
//    the design pulses addr_valid and checks addr_out holds otherwise.
//
// Ports:
//    none (top-level bench)
// ---------------------------------------------------------------------------
module tb_ap_pointer_file;

   localparam int          W         = 16;
   localparam logic [15:0] RESET_VAL = 16'h0000;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_INC    = 3'b010;
   localparam logic [2:0] OP_DEC    = 3'b011;
   localparam logic [2:0] OP_ADD    = 3'b100;
   localparam logic [2:0] OP_READ   = 3'b101;
   localparam logic [2:0] OP_CLRALL = 3'b110;
   localparam logic [2:0] OP_RSVD   = 3'b111;

   logic          clk;
   logic          rst;
   logic [2:0]    APSel;
   logic          op_valid;
   logic [2:0]    op;
   logic [W-1:0]  data_in;
   logic          op_ready;
   logic [W-1:0]  addr_out;
   logic          addr_valid;
   logic          wrap;

   typedef struct {
      logic [15:0] addr;
      logic        wrap;
   } exp_t;

   exp_t        expQ[$];
   logic [15:0] mPtr [8];
   int          mBusy;
   logic [15:0] lastAddr;
   int          total;
   int          bad;

   ap_pointer_file #(
      .ADDR_W    (W),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .APSel      (APSel),
      .op_valid   (op_valid),
      .op         (op),
      .data_in    (data_in),
      .op_ready   (op_ready),
      .addr_out   (addr_out),
      .addr_valid (addr_valid),
      .wrap       (wrap)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Drives one cycle of stimulus on the falling edge. The model decides on
   // its own whether the command is accepted (no sweep in progress), updates
   // the pointer array with unbounded arithmetic and pushes the expected
   // response. The sweep length is tracked as a simple countdown of edges.
   task automatic applyStimulus(input logic v, input logic [2:0] sel,
                                input logic [2:0] o, input logic [15:0] d);
      logic   acc;
      longint t;
      exp_t   e;
      @(negedge clk);
      checkOutput("op_ready", {31'b0, op_ready}, {31'b0, (mBusy == 0)});
      op_valid = v;
      APSel    = sel;
      op       = o;
      data_in  = d;
      acc      = v && (mBusy == 0);
      if (acc) begin
         case (o)
            OP_LOAD: begin
               mPtr[sel] = d;
               e.addr = d;
               e.wrap = 1'b0;
               expQ.push_back(e);
            end
            OP_INC, OP_DEC, OP_ADD: begin
               if (o == OP_INC)      t = longint'(mPtr[sel]) + 1;
               else if (o == OP_DEC) t = longint'(mPtr[sel]) - 1;
               else                  t = longint'(mPtr[sel]) + longint'($signed(d));
               e.wrap = (t < 0) || (t > 65535);
               e.addr = t[15:0];
               mPtr[sel] = e.addr;
               expQ.push_back(e);
            end
            OP_READ: begin
               e.addr = mPtr[sel];
               e.wrap = 1'b0;
               expQ.push_back(e);
            end
            OP_CLRALL: begin
               for (int i = 0; i < 8; i++) mPtr[i] = RESET_VAL;
            end
            default: begin
            end
         endcase
      end
      @(posedge clk);
      if (acc && o == OP_CLRALL) mBusy = 8;
      else if (mBusy > 0)        mBusy--;
   endtask

   // Synchronous reset pulse covering one rising edge.
   task automatic resetDut();
      @(negedge clk);
      rst      = 1'b1;
      op_valid = 1'b0;
      expQ.delete();
      for (int i = 0; i < 8; i++) mPtr[i] = RESET_VAL;
      mBusy = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: samples just after each rising edge. A pulse on addr_valid
   // must match the oldest expected response; otherwise addr_out must hold
   // the last reported value and wrap must stay low.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            checkOutput("reset addr_valid", {31'b0, addr_valid}, 32'd0);
            checkOutput("reset addr_out", {16'b0, addr_out}, 32'd0);
            checkOutput("reset wrap", {31'b0, wrap}, 32'd0);
            lastAddr = 16'h0000;
         end else if (addr_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected addr_valid", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("addr_out", {16'b0, addr_out}, {16'b0, e.addr});
               checkOutput("wrap", {31'b0, wrap}, {31'b0, e.wrap});
               lastAddr = e.addr;
            end
         end else begin
            checkOutput("addr_out hold", {16'b0, addr_out}, {16'b0, lastAddr});
            checkOutput("wrap idle", {31'b0, wrap}, 32'd0);
         end
      end
   end

   // Main sequence: directed scenarios first, then a randomized run.
   initial begin
      logic [2:0]  ro;
      logic [15:0] rd;
      total    = 0;
      bad      = 0;
      mBusy    = 0;
      lastAddr = 16'h0000;
      rst      = 1'b1;
      op_valid = 1'b0;
      APSel    = 3'd0;
      op       = OP_NOP;
      data_in  = 16'h0000;
      for (int i = 0; i < 8; i++) mPtr[i] = RESET_VAL;

      resetDut();

      // All pointers read back as zero after reset.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), OP_READ, 16'h0000);

      // Load, increment, read on one pointer; others untouched.
      applyStimulus(1'b1, 3'd3, OP_LOAD, 16'h1234);
      applyStimulus(1'b1, 3'd3, OP_INC,  16'h0000);
      applyStimulus(1'b1, 3'd3, OP_READ, 16'h0000);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), OP_READ, 16'h0000);

      // Wrap boundaries.
      applyStimulus(1'b1, 3'd5, OP_LOAD, 16'hFFFF);
      applyStimulus(1'b1, 3'd5, OP_INC,  16'h0000);
      applyStimulus(1'b1, 3'd5, OP_DEC,  16'h0000);
      applyStimulus(1'b1, 3'd5, OP_ADD,  16'hFFFE);
      applyStimulus(1'b1, 3'd1, OP_LOAD, 16'h0001);
      applyStimulus(1'b1, 3'd1, OP_ADD,  16'hFFFC);
      applyStimulus(1'b1, 3'd2, OP_LOAD, 16'hFFF0);
      applyStimulus(1'b1, 3'd2, OP_ADD,  16'h0020);

      // Distinct loads, then CLRALL with a held command that is refused
      // for eight cycles and accepted on the ninth.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), OP_LOAD, 16'h1000 + 16'(i * 17));
      applyStimulus(1'b1, 3'd0, OP_CLRALL, 16'h0000);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 3'd2, OP_LOAD, 16'hBEEF);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), OP_READ, 16'h0000);

      // Reset during the fourth cycle of a sweep.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), OP_LOAD, 16'hA000 + 16'(i));
      applyStimulus(1'b1, 3'd0, OP_CLRALL, 16'h0000);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, OP_NOP, 16'h0000);
      resetDut();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), OP_READ, 16'h0000);

      // NOP and reserved opcode between loads.
      applyStimulus(1'b1, 3'd4, OP_LOAD, 16'h00AA);
      applyStimulus(1'b1, 3'd4, OP_NOP,  16'h1111);
      applyStimulus(1'b1, 3'd4, OP_RSVD, 16'h2222);
      applyStimulus(1'b1, 3'd6, OP_LOAD, 16'h0055);
      applyStimulus(1'b1, 3'd6, OP_NOP,  16'h3333);
      applyStimulus(1'b1, 3'd4, OP_READ, 16'h0000);

      // Randomized traffic with rare sweeps and occasional resets.
      for (int n = 0; n < 600; n++) begin
         ro = 3'($urandom_range(0, 7));
         if (ro == OP_CLRALL && $urandom_range(0, 7) != 0) ro = OP_READ;
         case ($urandom_range(0, 5))
            0:       rd = 16'hFFFF;
            1:       rd = 16'h0000;
            2:       rd = 16'h8000;
            3:       rd = 16'h0001;
            default: rd = 16'($urandom);
         endcase
         if ($urandom_range(0, 249) == 0) resetDut();
         applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ro, rd);
      end

      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 3'd0, OP_NOP, 16'h0000);
      checkOutput("queue drained", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
